// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M multiply/divide beside the execute-stage ALU |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITER);

  localparam logic [2:0] c_op_mul    = 3'b000;
  localparam logic [2:0] c_op_mulh   = 3'b001;
  localparam logic [2:0] c_op_mulhsu = 3'b010;
  localparam logic [2:0] c_op_mulhu  = 3'b011;
  localparam logic [2:0] c_op_div    = 3'b100;
  localparam logic [2:0] c_op_divu   = 3'b101;
  localparam logic [2:0] c_op_rem    = 3'b110;
  localparam logic [2:0] c_op_remu   = 3'b111;

  localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [2:0]      r_op;
  logic            r_neg_a, r_neg_b, r_bzero, r_ovf;
  logic [XLEN-1:0] r_srca, r_opnd, r_hi, r_lo, r_result;
  logic [CW-1:0]   r_cnt;

  logic            w_accept, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_quo_fix, w_rem_fix, w_fix;
  logic [XLEN:0]   w_sum, w_shl, w_diff;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;

  assign w_accept = (r_state == S_IDLE) && start && !flush;

  assign w_sgn_a = (op == c_op_mulh) || (op == c_op_mulhsu) || (op == c_op_div) || (op == c_op_rem);
  assign w_sgn_b = (op == c_op_mulh) || (op == c_op_div) || (op == c_op_rem);
  assign w_neg_a = w_sgn_a && srca[XLEN-1];
  assign w_neg_b = w_sgn_b && srcb[XLEN-1];
  assign w_mag_a = w_neg_a ? -srca : srca;
  assign w_mag_b = w_neg_b ? -srcb : srcb;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
      S_CALC:  if (flush) w_state_nxt = S_IDLE;
               else if (r_cnt == '0) w_state_nxt = S_FIXUP;
      S_FIXUP: w_state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiply: add-then-shift right, multiplier bits drain out of r_lo as product bits enter.
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  // Divide: remainder in r_hi, dividend shifts out of r_lo while quotient bits shift in.
  assign w_shl  = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_shl - {1'b0, r_opnd};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_op     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_bzero  <= 1'b0;
      r_ovf    <= 1'b0;
      r_srca   <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= op;
        r_neg_a <= w_neg_a;
        r_neg_b <= w_neg_b;
        r_bzero <= (srcb == '0);
        r_ovf   <= (srca == c_int_min) && (&srcb);
        r_srca  <= srca;
        r_hi    <= '0;
        r_cnt   <= CW'(ITER - 1);
        r_opnd  <= op[2] ? w_mag_b : w_mag_a;
        r_lo    <= op[2] ? w_mag_a : w_mag_b;
      end else if (r_state == S_CALC && !flush) begin
        r_cnt <= r_cnt - 1'b1;
        if (!r_op[2]) begin
          r_hi <= w_sum[XLEN:1];
          r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
        end else if (!w_diff[XLEN]) begin
          r_hi <= w_diff[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b1};
        end else begin
          r_hi <= w_shl[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b0};
        end
      end
      if (r_state == S_FIXUP && !flush) r_result <= w_fix;
    end
  end

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
  assign w_rem_fix  = r_neg_a ? -r_hi : r_hi;

  always_comb begin
    w_fix = '0;
    case (r_op)
      c_op_mul:                          w_fix = w_prod_fix[XLEN-1:0];
      c_op_mulh, c_op_mulhsu, c_op_mulhu: w_fix = w_prod_fix[2*XLEN-1:XLEN];
      c_op_div:  w_fix = r_bzero ? '1 : (r_ovf ? c_int_min : w_quo_fix);
      c_op_divu: w_fix = r_bzero ? '1 : w_quo_fix;
      c_op_rem:  w_fix = r_bzero ? r_srca : (r_ovf ? '0 : w_rem_fix);
      c_op_remu: w_fix = r_bzero ? r_srca : w_rem_fix;
      default:   w_fix = '0;
    endcase
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_unit : directed-vector bench for muldiv_unit                     |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n, start, flush;
  logic [2:0]  op;
  logic [31:0] srca, srcb;
  logic        busy, done;
  logic [31:0] result;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .ITER(32)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .flush   (flush),
    .op      (op),
    .srca    (srca),
    .srcb    (srcb),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op from IDLE, scrambles operands after accept, checks latency, busy span and result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n, bc;
    op = o; srca = a; srcb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); srca = $urandom; srcb = $urandom;
    n  = 1;
    bc = busy ? 1 : 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (busy) bc++;
    end
    check({tag, " latency"}, 32'(n), 32'd34);
    check({tag, " busy"}, 32'(bc), 32'd34);
    check({tag, " result"}, result, exp);
    @(posedge clk); #1;
    check({tag, " idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; srca = '0; srcb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    reset_n = 1'b1;

    run_op("mul",    3'b000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE);
    run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'h2, 32'h00000001);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
    run_op("mulh min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000);

    // Reset at CALC cycle 10 of a DIV.
    op = 3'b100; srca = 32'hFFFFFFF9; srcb = 32'h2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset result", result, 32'd0);
    run_op("post reset divu", 3'b101, 32'd7, 32'd2, 32'd3);

    run_op("div -7/2",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_op("rem -7/2",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_op("divu 7/2",  3'b101, 32'd7, 32'd2, 32'd3);
    run_op("remu 7/2",  3'b111, 32'd7, 32'd2, 32'd1);
    run_op("div 100/-7", 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2);
    run_op("rem 100/-7", 3'b110, 32'd100, 32'hFFFFFFF9, 32'd2);
    run_op("divu big",  3'b101, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF);
    run_op("div 5/0",   3'b100, 32'd5, 32'd0, 32'hFFFFFFFF);
    run_op("remu 5/0",  3'b111, 32'd5, 32'd0, 32'd5);
    run_op("div ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("rem ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);

    // start held high: second completion 35 cycles after the first.
    op = 3'b101; srca = 32'd7; srcb = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b first latency", 32'(n), 32'd34);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 80);
    start = 1'b0;
    check("b2b interval", 32'(n), 32'd35);
    check("b2b result", result, 32'd3);
    @(posedge clk); #1;
    check("b2b idle", {31'd0, busy}, 32'd0);

    // start together with flush in IDLE is ignored.
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idle flush busy", {31'd0, busy}, 32'd0);

    // Flush at CALC cycle 5 keeps the previous result.
    run_op("mul 3*4", 3'b000, 32'd3, 32'd4, 32'd12);
    op = 3'b000; srca = 32'd5; srcb = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("flush no done", 32'(n), 32'd0);
    check("flush result", result, 32'd12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
